// File: rtl/pipeline_pkg.sv
// Shared types for the MEM-stage data memory path: request/response records
// and the responder FSM state encoding.
package pipeline_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } dmem_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Expands byte-lane strobes into a per-bit write mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-lane write, combinational
// full-word read at the same index.
module dmem_array
  import pipeline_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] wmask;

  assign wmask = be_to_mask(be);

  // NOTE: the storage has no reset; contents must survive a responder reset,
  // and resetting a RAM array would also prevent memory-macro inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one request at a time, inserts
// WAIT_CYCLES wait states, performs the access, then holds the response.
module dmem_responder
  import pipeline_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;
  dmem_resp_t        resp_q, resp_d;
  dmem_req_t         in_req, acc_req;
  logic              mem_en;
  logic [ADDR_W-3:0] acc_word;
  logic              acc_err;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_byte_offset;

  assign in_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    resp_d  = resp_q;
    acc_req = req_q;
    mem_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the access uses the live request on the accepting edge.
            acc_req = in_req;
            mem_en  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          mem_en  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_en) begin
      resp_d.err   = acc_err;
      resp_d.rdata = (acc_err || acc_req.we) ? '0 : mem_rdata;
    end
  end

  assign acc_word           = acc_req.addr[ADDR_W-1:2];
  assign acc_err            = 32'(acc_word) >= 32'(DEPTH_WORDS);
  assign unused_byte_offset = ^acc_req.addr[1:0];

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // does not appear in the sensitivity list; state uses non-blocking assigns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // The write is gated by reset so a store pending in WAIT is never committed.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_en && reset && acc_req.we && !acc_err),
    .idx   (acc_word[IDX_W-1:0]),
    .wdata (acc_req.wdata),
    .be    (acc_req.be),
    .rdata (mem_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of loads/stores on a
// WAIT_CYCLES=2 instance plus hand-written reset, backpressure and zero-wait cases.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_we, z_resp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request at the falling edge, lets it be accepted on the next
  // rising edge, then scrambles the request fields (they must be ignored).
  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic rr, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = rr;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    req_be = 4'($urandom);
  endtask

  // Counts rising edges after acceptance until resp_valid; bounded.
  task automatic wait_resp(input string tag);
    int lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    start_req(v.we, v.addr, v.wdata, v.be, 1'b1, tag);
    wait_resp(tag);
    check({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(v.exp_err));
    @(posedge clk); #1;
    check({tag, "_released"}, 32'({resp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h13,   32'h0,        4'hF, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b1, 32'h10,   32'h11223344, 4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{1'b1, 32'h10,   32'h55667788, 4'hA, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h11,   32'h0,        4'h0, 32'h55AD77AA, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,    4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h20,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0});

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; resp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_req_be = '0; z_resp_ready = 1'b1;

    // Reset held low for two edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'({req_ready, resp_valid, resp_err}), 32'b100);
    check("rst_rdata", resp_rdata, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", 32'({req_ready, resp_valid, resp_err}), 32'b100);
    check("post_rst_rdata", resp_rdata, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Backpressure: response held for five edges, consumed on the sixth.
    start_req(1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, "bp");
    wait_resp("bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_flags", k), 32'({resp_valid, req_ready}), 32'b10);
      check($sformatf("bp_hold%0d_rdata", k), resp_rdata, 32'hCAFEF00D);
    end
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_consumed", 32'({resp_valid, req_ready}), 32'b01);

    // Reset during WAIT cancels a pending store.
    start_req(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, "rw");
    check("rw_in_wait", 32'({resp_valid, req_ready}), 32'b00);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rw_rst_flags", 32'({req_ready, resp_valid, resp_err}), 32'b100);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rw_no_resp", 32'(resp_valid), 32'd0);
    run_txn('{1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0}, "rw_load");

    // Reset during RESP drops the response without resp_ready.
    start_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rr");
    wait_resp("rr");
    check("rr_rdata", resp_rdata, 32'h55AD77AA);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rr_dropped", 32'({req_ready, resp_valid, resp_err}), 32'b100);
    check("rr_rdata_clr", resp_rdata, 32'h0);
    @(negedge clk) reset = 1'b1; resp_ready = 1'b1;

    // Zero wait states: response visible right after the accepting edge.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'h0BADF00D;
    z_req_be = 4'hF; z_resp_ready = 1'b0;
    check("z_st_ready", 32'({z_req_ready, z_resp_valid}), 32'b10);
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("z_st_resp", 32'({z_resp_valid, z_req_ready, z_resp_err}), 32'b100);
    check("z_st_rdata", z_resp_rdata, 32'h0);
    @(negedge clk) z_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("z_st_consumed", 32'(z_resp_valid), 32'd0);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h43; z_req_be = 4'h0;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("z_ld_valid", 32'(z_resp_valid), 32'd1);
    check("z_ld_rdata", z_resp_rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    check("z_ld_consumed", 32'({z_resp_valid, z_req_ready}), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary line");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between request acceptance and response (0 legal).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  requester (MEM stage) presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata  input  32  store data, lane-aligned.
REQ-010 SHALL have port req_be  input  4  byte-lane write strobes; bit i covers bits 8i+7:8i.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  requester consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  load data (full word).
REQ-014 SHALL have port resp_err  output  1  access fault (out-of-range address).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-017 SHALL accept a request on an edge where req_valid & req_ready, latching we/addr/wdata/be.
REQ-018 On acceptance SHALL go to WAIT with counter=WAIT_CYCLES, or directly to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT SHALL decrement counter each cycle and move to RESP on the edge where counter equals 1.
REQ-020 resp_valid SHALL first be high in the cycle after edge N+WAIT_CYCLES, where N is the accepting edge.
REQ-021 SHALL perform the memory access on the edge entering RESP, never earlier.
REQ-022 Load: resp_rdata SHALL equal the full stored word at word index; req_be ignored; addr[1:0] ignored.
REQ-023 Store: SHALL update only bytes with be bit set; resp_rdata SHALL be 0; be=0 is a legal no-op store.
REQ-024 Word index >= DEPTH_WORDS: resp_err=1, resp_rdata=0, no memory update; otherwise resp_err=0.
REQ-025 In RESP, resp_rdata and resp_err SHALL stay stable until the edge where resp_ready=1, then return to IDLE.
REQ-026 SHALL NOT accept a new request in the same cycle a response is consumed (req_ready low in RESP).
REQ-027 Store followed by load to same word SHALL return the stored data (no hazard window).
REQ-028 Inputs other than handshake signals SHALL be ignored outside the accepting edge.

Reset
REQ-029 reset low at an edge SHALL force IDLE, counter=0, req_ready=1 after the edge, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 Reset during WAIT SHALL cancel the pending access; a pending store SHALL NOT be committed.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Reset during RESP SHALL drop the response without requiring resp_ready.

Structure
REQ-033 Request/response structs (dmem_req_t, dmem_resp_t) and FSM state enum SHALL live in pipeline_pkg.
REQ-034 Storage SHALL be a sub-module dmem_array: synchronous byte-lane write, word read, index width $clog2(DEPTH_WORDS).
REQ-035 FSM, counter, and range check SHALL reside in dmem_responder.

Verification
REQ-036 Reset low 2 cycles, then high -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-037 WAIT_CYCLES=2: store 0xDEADBEEF be=1111 to 0x10 at edge N -> resp_valid at edge N+2, rdata=0; load 0x10 -> 0xDEADBEEF.
REQ-038 Store 0x000000AA be=0001 to 0x10 over 0xDEADBEEF; load 0x13 -> 0xDEADBEAA.
REQ-039 Load 0x1000 with DEPTH_WORDS=1024 -> resp_err=1, rdata=0; memory unchanged.
REQ-040 resp_ready held low 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0 throughout; consumed on 6th edge.
REQ-041 Store 0x12345678 to 0x20 then reset low during WAIT -> load 0x20 returns prior contents; WAIT_CYCLES=0 load -> resp_valid at edge N.
